ysyx_23060201_fetch_unit: RTL and testbench
===========================================

Name: ysyx_23060201_fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the single-cycle core's decode/execute datapath. Owns the architectural PC. Issues one instruction read per instruction over a valid/ready memory interface. Presents the returned word to the decoder with a valid/ready handshake, then waits for the execute stage to return the next PC before fetching again. Replaces the fixed `inst` input the core top currently takes, so instruction memory latency becomes variable.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset.
XLEN, 32, width of PC, address and instruction.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  synchronous, active-low reset; sampled on rising clk.
pc  out  XLEN  current fetch PC.
mem_req_valid  out  1  read request valid.
mem_req_ready  in  1  memory accepts request.
mem_req_addr  out  XLEN  request address; equals pc.
mem_resp_valid  in  1  read data valid.
mem_resp_ready  out  1  fetch unit accepts response.
mem_resp_data  in  XLEN  instruction word.
mem_resp_err  in  1  memory access error, qualified by mem_resp_valid.
inst_valid  out  1  inst holds a fetched instruction.
inst_ready  in  1  downstream consumes inst.
inst  out  XLEN  fetched instruction, held stable while inst_valid.
fetch_err  out  1  fault flag accompanying inst, qualified by inst_valid.
dnpc_valid  in  1  execute stage presents next PC.
dnpc  in  XLEN  next PC from execute.

Behaviour:
- Reset (rst==0 at a rising edge):
  - pc=RESET_PC; state=REQ.
  - inst=0; inst_valid=0; fetch_err=0.
  - mem_req_valid=0 during the reset cycle.
  - Reset mid-operation aborts any phase; the bench resets memory in the same cycle.
- FSM states REQ, WAIT, OUT, NPC.
- REQ:
  - mem_req_valid=1; mem_req_addr=pc.
  - On mem_req_valid&&mem_req_ready, go to WAIT.
  - Address and valid stay stable until accepted.
- WAIT:
  - mem_resp_ready=1; mem_resp_ready is 0 in every other state.
  - On mem_resp_valid, latch inst=mem_resp_data and fetch_err=mem_resp_err, then go to OUT.
  - Zero-latency memory (response in the cycle after acceptance) is legal.
  - Minimum request-to-inst_valid time is 2 cycles.
- OUT:
  - inst_valid=1.
  - inst and fetch_err are held stable until inst_valid&&inst_ready.
  - On handshake: inst_valid=0 next cycle, go to NPC.
- NPC:
  - Waits for dnpc_valid. When it arrives: pc<=dnpc and go to REQ.
  - The new request asserts the cycle after dnpc_valid.
- Simultaneous inst handshake and dnpc_valid in the same cycle (combinational execute path):
  - dnpc is taken in that cycle; state goes straight to REQ with pc=dnpc, skipping NPC.
- dnpc_valid in REQ or WAIT is ignored; pc is unchanged.
- pc changes only on reset or dnpc capture, never while a request is outstanding.
- Widths: no arithmetic on pc in this block. The pc+4 increment is the execute stage's job.
- fetch_err=1 does not stop the FSM. The word is delivered as-is, and sequencing continues normally.

Optional Feature:
IFU_ALIGN_CHK_EN:
- Defined:
  - In NPC, a captured dnpc with dnpc[1:0]!=0 skips the memory request.
  - The FSM enters OUT next cycle with inst=32'h0000_0013 (nop) and fetch_err=1.
  - pc holds the misaligned value.
- Undefined:
  - No check; dnpc[1:0] passes to mem_req_addr unchanged.

Test Plan:
- Reset release, memory always ready, 1-cycle response of 32'h00100093 -> first mem_req_addr=32'h8000_0000; inst_valid rises 2 cycles after acceptance with inst=32'h00100093.
- Memory holds mem_req_ready=0 for 3 cycles -> mem_req_valid=1 and mem_req_addr constant for all 4 cycles; exactly one request accepted.
- inst_ready=0 for 5 cycles while inst_valid=1 -> inst and fetch_err unchanged; no new mem_req_valid; pc unchanged.
- inst_ready=1 with dnpc_valid=1, dnpc=32'h8000_0004 in the same cycle -> next cycle pc=32'h8000_0004, mem_req_valid=1.
- dnpc_valid=1, dnpc=32'h1234_5678 pulsed while in WAIT -> ignored; pc stays; later dnpc=32'h8000_0010 in NPC is fetched.
- rst=0 asserted while in WAIT -> next cycle pc=32'h8000_0000, inst_valid=0, mem_req_valid=0; after rst=1, a new request to 32'h8000_0000 is issued.
- With IFU_ALIGN_CHK_EN, dnpc=32'h8000_0002 -> no memory request; inst=32'h0000_0013, fetch_err=1.

Source files
------------

// File: rtl/ysyx_23060201_fetch_unit.sv
// ysyx_23060201_fetch_unit: instruction fetch stage in front of the single-cycle core.
// Owns the architectural PC and fetches one word per instruction over a valid/ready
// memory port. It hands the word to decode with a valid/ready handshake, then waits for
// execute to return the next PC.
// Optional build macro IFU_ALIGN_CHK_EN: a misaligned next PC is not fetched. A faulting
// nop is delivered in its place.
module ysyx_23060201_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    output logic            mem_resp_ready,
    input  logic [XLEN-1:0] mem_resp_data,
    input  logic            mem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic            fetch_err,
    input  logic            dnpc_valid,
    input  logic [XLEN-1:0] dnpc
);

    typedef enum logic [1:0] {StReq, StWait, StOut, StNpc} state_e;

    localparam logic [XLEN-1:0] NopInst = XLEN'(32'h0000_0013);

    state_e state_q;
    logic   inst_hs;
    logic   take_dnpc;
    logic   dnpc_misaligned;

    // The request address is the PC itself; PC never moves while a request is pending.
    assign mem_req_addr = pc;

    assign inst_hs = inst_valid && inst_ready;

    // Execute may answer combinationally in the same cycle decode consumes the word,
    // so a dnpc is taken either in NPC or together with the inst handshake in OUT.
    assign take_dnpc = dnpc_valid && ((state_q == StNpc) || ((state_q == StOut) && inst_hs));

`ifdef IFU_ALIGN_CHK_EN
    assign dnpc_misaligned = |dnpc[1:0];
`else
    assign dnpc_misaligned = 1'b0;
`endif

    // Fetch sequencer; every handshake output is a register so downstream sees clean edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StReq;
            pc             <= RESET_PC;
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            fetch_err      <= 1'b0;
        end else if (take_dnpc) begin
            pc <= dnpc;
            if (dnpc_misaligned) begin
                // Skip memory entirely and deliver a faulting nop at the misaligned PC.
                state_q    <= StOut;
                inst       <= NopInst;
                fetch_err  <= 1'b1;
                inst_valid <= 1'b1;
            end else begin
                state_q       <= StReq;
                mem_req_valid <= 1'b1;
                inst_valid    <= 1'b0;
            end
        end else begin
            unique case (state_q)
                StReq: begin
                    // Valid is low only in the first cycle after reset.
                    if (!mem_req_valid) begin
                        mem_req_valid <= 1'b1;
                    end else if (mem_req_ready) begin
                        mem_req_valid  <= 1'b0;
                        mem_resp_ready <= 1'b1;
                        state_q        <= StWait;
                    end
                end
                StWait: begin
                    if (mem_resp_valid) begin
                        inst           <= mem_resp_data;
                        fetch_err      <= mem_resp_err;
                        mem_resp_ready <= 1'b0;
                        inst_valid     <= 1'b1;
                        state_q        <= StOut;
                    end
                end
                StOut: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state_q    <= StNpc;
                    end
                end
                StNpc: begin
                    // Only a dnpc capture leaves this state.
                end
                default: begin
                    state_q <= StReq;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_fetch_unit.sv
// Bench for ysyx_23060201_fetch_unit: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level model of the fetch contract.
module tb_ysyx_23060201_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        fetch_err;
    logic        dnpc_valid;
    logic [31:0] dnpc;

    ysyx_23060201_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .fetch_err      (fetch_err),
        .dnpc_valid     (dnpc_valid),
        .dnpc           (dnpc)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents and fault map.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic mem_fault(input logic [31:0] a);
        return a[4] ^ a[9];
    endfunction

    // Reference model: addresses still owed to memory, the outstanding read, the word owed
    // to decode, and whether the core is owed a next PC.
    logic [31:0] exp_addr_q[$];
    logic        pending;
    int          lat;
    logic [31:0] resp_addr;
    logic        inst_avail;
    logic [31:0] exp_inst;
    logic        exp_err;
    logic        awaiting;
    logic [31:0] cur_pc;
    logic        just_cap;
    int unsigned n_hs = 0;

    // Stimulus knobs for the next cycle.
    logic        k_rst;
    logic        k_req_ready;
    logic        k_inst_ready;
    logic        k_dnpc_valid;
    logic [31:0] k_dnpc;
    int          k_lat;

    // Values present during the previous cycle, i.e. what the last edge sampled.
    logic        p_rst;
    logic        p_req_v, p_req_r;
    logic        p_resp_v, p_resp_r;
    logic        p_inst_v, p_inst_r;
    logic        p_dnpc_v;
    logic [31:0] p_dnpc;

    task automatic model_reset();
        exp_addr_q.delete();
        exp_addr_q.push_back(RESET_PC);
        pending    = 1'b0;
        lat        = 0;
        inst_avail = 1'b0;
        awaiting   = 1'b0;
        cur_pc     = RESET_PC;
    endtask

    task automatic tick();
        logic hs;
        @(posedge clk);
        #1;
        hs       = 1'b0;
        just_cap = 1'b0;
        if (!p_rst) begin
            model_reset();
            check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
            check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
            check("rst_inst", inst, 32'd0);
            check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        end else begin
            if (p_resp_v && p_resp_r) begin
                pending    = 1'b0;
                inst_avail = 1'b1;
            end
            if (p_req_v && p_req_r) begin
                if (exp_addr_q.size() == 0) begin
                    check("spurious_req", {31'b0, p_req_v}, 32'd0);
                end else begin
                    resp_addr = exp_addr_q.pop_front();
                    pending   = 1'b1;
                    lat       = k_lat;
                    exp_inst  = mem_word(resp_addr);
                    exp_err   = mem_fault(resp_addr);
                end
            end
            if (p_inst_v && p_inst_r) begin
                hs         = 1'b1;
                inst_avail = 1'b0;
                n_hs++;
            end
            if (p_dnpc_v && (hs || awaiting)) begin
                cur_pc   = p_dnpc;
                awaiting = 1'b0;
                just_cap = 1'b1;
`ifdef IFU_ALIGN_CHK_EN
                if (p_dnpc[1:0] != 2'b00) begin
                    inst_avail = 1'b1;
                    exp_inst   = 32'h0000_0013;
                    exp_err    = 1'b1;
                    just_cap   = 1'b0;
                end else begin
                    exp_addr_q.push_back(p_dnpc);
                end
`else
                exp_addr_q.push_back(p_dnpc);
`endif
            end else if (hs) begin
                awaiting = 1'b1;
            end
        end

        check("pc", pc, cur_pc);
        check("resp_ready", {31'b0, mem_resp_ready}, {31'b0, pending});
        check("inst_valid", {31'b0, inst_valid}, {31'b0, inst_avail});
        if (inst_avail) begin
            check("inst", inst, exp_inst);
            check("fetch_err", {31'b0, fetch_err}, {31'b0, exp_err});
        end
        if (exp_addr_q.size() == 0) begin
            check("no_req", {31'b0, mem_req_valid}, 32'd0);
        end else begin
            check("req_addr", mem_req_addr, exp_addr_q[0]);
            if (just_cap) check("req_after_dnpc", {31'b0, mem_req_valid}, 32'd1);
        end

        // Drive the next cycle; the memory resets together with the core.
        rst            = k_rst;
        mem_req_ready  = k_req_ready;
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
        mem_resp_err   = 1'($urandom_range(0, 1));
        if (pending && k_rst) begin
            if (lat == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_word(resp_addr);
                mem_resp_err   = mem_fault(resp_addr);
            end else begin
                lat--;
            end
        end
        inst_ready = k_inst_ready;
        dnpc_valid = k_dnpc_valid;
        dnpc       = k_dnpc;

        p_rst    = rst;
        p_req_v  = mem_req_valid;
        p_req_r  = mem_req_ready;
        p_resp_v = mem_resp_valid;
        p_resp_r = mem_resp_ready;
        p_inst_v = inst_valid;
        p_inst_r = inst_ready;
        p_dnpc_v = dnpc_valid;
        p_dnpc   = dnpc;
    endtask

    task automatic rand_knobs();
        k_rst        = ($urandom_range(0, 299) != 0);
        k_req_ready  = ($urandom_range(0, 9) < 6);
        k_inst_ready = 1'($urandom_range(0, 1));
        k_dnpc_valid = ($urandom_range(0, 9) < 3);
        k_dnpc       = {16'h8000, 16'($urandom)} & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) k_dnpc[1:0] = 2'($urandom_range(1, 3));
        k_lat        = $urandom_range(0, 3);
    endtask

    initial begin
        rst = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        mem_resp_err = 1'b0; inst_ready = 1'b0; dnpc_valid = 1'b0; dnpc = '0;
        p_rst = 1'b0; p_req_v = 1'b0; p_req_r = 1'b0; p_resp_v = 1'b0; p_resp_r = 1'b0;
        p_inst_v = 1'b0; p_inst_r = 1'b0; p_dnpc_v = 1'b0; p_dnpc = '0;
        exp_inst = '0; exp_err = 1'b0; resp_addr = '0;
        model_reset();

        // Reset, then first fetch with an always-ready, zero-latency memory; hold inst.
        k_rst = 1'b0; k_req_ready = 1'b1; k_inst_ready = 1'b0; k_dnpc_valid = 1'b0;
        k_dnpc = '0; k_lat = 0;
        repeat (2) tick();
        k_rst = 1'b1;
        repeat (10) tick();

        // Consume with dnpc in the same cycle, then stall the request for 3 cycles.
        k_inst_ready = 1'b1; k_dnpc_valid = 1'b1; k_dnpc = 32'h8000_0004;
        tick();
        k_inst_ready = 1'b0; k_dnpc_valid = 1'b0; k_req_ready = 1'b0;
        repeat (3) tick();
        k_req_ready = 1'b1; k_lat = 3;
        repeat (2) tick();

        // A dnpc pulse while waiting on memory must be ignored.
        k_dnpc_valid = 1'b1; k_dnpc = 32'h1234_5678;
        tick();
        k_dnpc_valid = 1'b0;
        repeat (5) tick();
        k_inst_ready = 1'b1;
        tick();
        k_inst_ready = 1'b0;
        repeat (2) tick();
        k_dnpc_valid = 1'b1; k_dnpc = 32'h8000_0010;
        tick();
        k_dnpc_valid = 1'b0;
        repeat (3) tick();

        // Reset while a response is outstanding.
        k_rst = 1'b0;
        tick();
        k_rst = 1'b1;
        repeat (6) tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_knobs();
            tick();
        end

        check("progress", {31'b0, (n_hs > 100)}, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
